// File: rtl/vga_layer_arbiter_pkg.sv
// Shared constants and types for the sprite-layer arbiter: display geometry,
// sprite size, colour keys and the commit state encoding.
package vga_layer_arbiter_pkg;

  localparam int N_LAYER    = 4;
  localparam int SPR_W      = 32;
  localparam int SPR_H      = 32;
  localparam int COLOR_W    = 12;
  localparam int H_DISP_LEN = 10;
  localparam int V_DISP_LEN = 9;

  localparam int LAYER_W = $clog2(N_LAYER);
  localparam int SPR_XB  = $clog2(SPR_W);
  localparam int SPR_YB  = $clog2(SPR_H);
  localparam int ADDR_W  = $clog2(N_LAYER * SPR_W * SPR_H);

  localparam logic [COLOR_W-1:0] TRANSP_KEY = 12'hF0F;
  localparam logic [COLOR_W-1:0] BG_COLOR   = 12'h000;

  typedef enum logic {
    C_IDLE    = 1'b0,
    C_PENDING = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic                  vis;
    logic [H_DISP_LEN-1:0] x;
    logic [V_DISP_LEN-1:0] y;
  } layer_pos_t;

endpackage

// File: rtl/vga_layer_arbiter_layer_hit_test.sv
// Coverage test for one sprite layer: does the look-ahead pixel fall inside
// the sprite box, and where inside it.
module vga_layer_arbiter_layer_hit_test
  import vga_layer_arbiter_pkg::*;
(
  input  logic [H_DISP_LEN-1:0] req_x,
  input  logic [V_DISP_LEN-1:0] req_y,
  input  layer_pos_t            pos,
  output logic                  hit,
  output logic [SPR_XB-1:0]     dx,
  output logic [SPR_YB-1:0]     dy
);

  logic [H_DISP_LEN:0] dx_full;
  logic [V_DISP_LEN:0] dy_full;

  // The extra MSB is the borrow: set when the pixel lies left of / above the sprite.
  assign dx_full = {1'b0, req_x} - {1'b0, pos.x};
  assign dy_full = {1'b0, req_y} - {1'b0, pos.y};

  assign hit = pos.vis
             && !dx_full[H_DISP_LEN] && (dx_full[H_DISP_LEN-1:0] < H_DISP_LEN'(SPR_W))
             && !dy_full[V_DISP_LEN] && (dy_full[V_DISP_LEN-1:0] < V_DISP_LEN'(SPR_H));

  assign dx = dx_full[SPR_XB-1:0];
  assign dy = dy_full[SPR_YB-1:0];

endmodule

// File: rtl/vga_layer_arbiter.sv
// Shares one sprite ROM port between N_LAYER layers: picks the top covering layer
// for the look-ahead pixel, reads its texel and lands it on the scanned pixel 2 cycles later.
module vga_layer_arbiter
  import vga_layer_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  disp_i,
  input  logic                  frame_start_i,
  input  logic [H_DISP_LEN-1:0] req_x_i,
  input  logic [V_DISP_LEN-1:0] req_y_i,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [LAYER_W-1:0]    upd_layer_i,
  input  logic                  upd_vis_i,
  input  logic [H_DISP_LEN-1:0] upd_x_i,
  input  logic [V_DISP_LEN-1:0] upd_y_i,
  input  logic                  commit_req_i,
  output logic                  commit_ack_o,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [COLOR_W-1:0]    rom_data_i,
  output logic [COLOR_W-1:0]    rgb_o,
  output logic [LAYER_W:0]      hit_layer_o,
  output commit_state_t         commit_state
);

  layer_pos_t    shadow [N_LAYER];
  layer_pos_t    active [N_LAYER];
  commit_state_t state;

  // Shadow handshake: a write transfers on any clock where upd_valid_i and
  // upd_ready_o are both high; ready is low only while a commit is pending.
  assign upd_ready_o  = (state == C_IDLE);
  assign commit_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LAYER; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N_LAYER; i++) begin
        if (upd_valid_i && upd_ready_o && upd_layer_i == LAYER_W'(i))
          shadow[i] <= '{vis: upd_vis_i, x: upd_x_i, y: upd_y_i};
      end
    end
  end

  // Active positions only change on the frame boundary so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= C_IDLE;
      commit_ack_o <= 1'b0;
      for (int i = 0; i < N_LAYER; i++) active[i] <= '0;
    end else begin
      commit_ack_o <= 1'b0;
      case (state)
        C_IDLE: begin
          if (commit_req_i) state <= C_PENDING;
        end
        C_PENDING: begin
          if (frame_start_i) begin
            active       <= shadow;
            commit_ack_o <= 1'b1;
            state        <= C_IDLE;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

  logic [N_LAYER-1:0] hit;
  logic [SPR_XB-1:0]  dx [N_LAYER];
  logic [SPR_YB-1:0]  dy [N_LAYER];

  for (genvar g = 0; g < N_LAYER; g++) begin : g_hit
    vga_layer_arbiter_layer_hit_test u_hit (
      .req_x (req_x_i),
      .req_y (req_y_i),
      .pos   (active[g]),
      .hit   (hit[g]),
      .dx    (dx[g]),
      .dy    (dy[g])
    );
  end

  logic               any_hit;
  logic [LAYER_W-1:0] win;
  logic [SPR_XB-1:0]  win_dx;
  logic [SPR_YB-1:0]  win_dy;

  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = N_LAYER - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        win     = LAYER_W'(i);
        win_dx  = dx[i];
        win_dy  = dy[i];
      end
    end
  end

  logic               hit1, hit2;
  logic [LAYER_W-1:0] win1, win2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_o <= '0;
      hit1       <= 1'b0;
      win1       <= '0;
      hit2       <= 1'b0;
      win2       <= '0;
    end else begin
      hit1 <= en_i && any_hit;
      win1 <= (en_i && any_hit) ? win : '0;
      // Address holds on a miss; the texel is ignored then anyway.
      if (en_i && any_hit) rom_addr_o <= {win, win_dy, win_dx};
      hit2 <= en_i && hit1;
      win2 <= en_i ? win1 : '0;
    end
  end

  // A transparent texel falls through to background, not to lower layers.
  always_comb begin
    rgb_o = '0;
    if (en_i && disp_i)
      rgb_o = (hit2 && rom_data_i != TRANSP_KEY) ? rom_data_i : BG_COLOR;
  end

  assign hit_layer_o = disp_i ? {hit2, win2} : '0;

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Randomised bench for vga_layer_arbiter with a geometric reference model
// and an expected-response queue drained by an independent monitor.
module tb_vga_layer_arbiter;
  import vga_layer_arbiter_pkg::*;

  localparam int EW = COLOR_W + LAYER_W + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  en_i = 1'b1;
  logic                  disp_i = 1'b0;
  logic                  frame_start_i = 1'b0;
  logic [H_DISP_LEN-1:0] req_x_i = '0;
  logic [V_DISP_LEN-1:0] req_y_i = '0;
  logic                  upd_valid_i = 1'b0;
  logic                  upd_ready_o;
  logic [LAYER_W-1:0]    upd_layer_i = '0;
  logic                  upd_vis_i = 1'b0;
  logic [H_DISP_LEN-1:0] upd_x_i = '0;
  logic [V_DISP_LEN-1:0] upd_y_i = '0;
  logic                  commit_req_i = 1'b0;
  logic                  commit_ack_o;
  logic [ADDR_W-1:0]     rom_addr_o;
  logic [COLOR_W-1:0]    rom_data_i = '0;
  logic [COLOR_W-1:0]    rgb_o;
  logic [LAYER_W:0]      hit_layer_o;
  commit_state_t         commit_state;

  vga_layer_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .disp_i        (disp_i),
    .frame_start_i (frame_start_i),
    .req_x_i       (req_x_i),
    .req_y_i       (req_y_i),
    .upd_valid_i   (upd_valid_i),
    .upd_ready_o   (upd_ready_o),
    .upd_layer_i   (upd_layer_i),
    .upd_vis_i     (upd_vis_i),
    .upd_x_i       (upd_x_i),
    .upd_y_i       (upd_y_i),
    .commit_req_i  (commit_req_i),
    .commit_ack_o  (commit_ack_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .rgb_o         (rgb_o),
    .hit_layer_o   (hit_layer_o),
    .commit_state  (commit_state)
  );

  // ---------------- clock and external ROM ----------------
  always #5 clk = ~clk;

  logic [COLOR_W-1:0] rom_mem [N_LAYER*SPR_W*SPR_H];
  always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

  // ---------------- reference model state ----------------
  int s_vis[N_LAYER], s_x[N_LAYER], s_y[N_LAYER];
  int a_vis[N_LAYER], a_x[N_LAYER], a_y[N_LAYER];
  bit m_pending = 0, m_ack = 0;
  int m_last_addr = 0;

  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  bit vq[2] = '{0, 0};
  bit dq[2] = '{0, 0};
  bit mon_valid = 0, addr_valid = 0, mon_on = 0;
  bit exp_ready = 1, exp_ack = 0, rst_chk = 0, prev_rst = 0;

  bit cmd_fs = 0, cmd_cr = 0, cmd_uv = 0, cmd_uvis = 0, cmd_rst = 0, cmd_en = 1;
  int cmd_ul = 0, cmd_ux = 0, cmd_uy = 0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Front-most visible layer whose 32x32 box contains the pixel.
  function automatic void ref_lookup(input int rx, input int ry,
                                     output bit h, output int w, output int addr);
    h = 0; w = 0; addr = 0;
    for (int l = 0; l < N_LAYER; l++) begin
      if (a_vis[l] != 0 && rx >= a_x[l] && rx < a_x[l] + SPR_W
                        && ry >= a_y[l] && ry < a_y[l] + SPR_H) begin
        h = 1;
        w = l;
        addr = l * SPR_W * SPR_H + (ry - a_y[l]) * SPR_W + (rx - a_x[l]);
        break;
      end
    end
  endfunction

  // One pixel clock: drive the request and controls, queue the expected
  // response, then advance the model past the coming clock edge.
  task automatic step(input int x, input int y, input bit d, input bit v);
    bit h;
    int w, a;
    logic [COLOR_W-1:0] px;
    logic [LAYER_W:0]   hl;
    logic [LAYER_W-1:0] wl;
    @(negedge clk);
    mon_valid = vq[1]; addr_valid = vq[0]; disp_i = dq[1];
    vq[1] = vq[0]; vq[0] = v; dq[1] = dq[0]; dq[0] = d;
    exp_ready = !m_pending; exp_ack = m_ack;
    rst_chk = prev_rst; prev_rst = cmd_rst;

    rst = cmd_rst; en_i = cmd_en;
    req_x_i = x[H_DISP_LEN-1:0]; req_y_i = y[V_DISP_LEN-1:0];
    frame_start_i = cmd_fs; commit_req_i = cmd_cr;
    upd_valid_i = cmd_uv; upd_layer_i = cmd_ul[LAYER_W-1:0]; upd_vis_i = cmd_uvis;
    upd_x_i = cmd_ux[H_DISP_LEN-1:0]; upd_y_i = cmd_uy[V_DISP_LEN-1:0];

    ref_lookup(x, y, h, w, a);
    if (cmd_rst || !cmd_en) h = 0;
    if (h) m_last_addr = a;
    if (cmd_rst) m_last_addr = 0;
    if (!(d && cmd_en)) px = '0;
    else if (h && rom_mem[a] != TRANSP_KEY) px = rom_mem[a];
    else px = BG_COLOR;
    wl = h ? w[LAYER_W-1:0] : '0;
    hl = d ? {h, wl} : '0;
    if (v) begin
      exp_q.push_back({px, hl});
      addr_q.push_back(m_last_addr[ADDR_W-1:0]);
    end

    if (cmd_rst) begin
      for (int l = 0; l < N_LAYER; l++) begin
        s_vis[l] = 0; s_x[l] = 0; s_y[l] = 0;
        a_vis[l] = 0; a_x[l] = 0; a_y[l] = 0;
      end
      m_pending = 0; m_ack = 0;
    end else begin
      if (cmd_uv && !m_pending && cmd_ul < N_LAYER) begin
        s_vis[cmd_ul] = cmd_uvis; s_x[cmd_ul] = cmd_ux; s_y[cmd_ul] = cmd_uy;
      end
      m_ack = 0;
      if (!m_pending) begin
        if (cmd_cr) m_pending = 1;
      end else if (cmd_fs) begin
        a_vis = s_vis; a_x = s_x; a_y = s_y;
        m_pending = 0; m_ack = 1;
      end
    end
    cmd_fs = 0; cmd_cr = 0; cmd_uv = 0; cmd_rst = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0]     e;
    logic [ADDR_W-1:0] ea;
    #1;
    if (mon_on) begin
      chk("upd_ready", upd_ready_o, exp_ready);
      chk("commit_ack", commit_ack_o, exp_ack);
      if (rst_chk) begin
        chk("reset_rom_addr", rom_addr_o, 0);
        chk("reset_hit_layer", hit_layer_o, 0);
        chk("reset_rgb", rgb_o, 0);
      end
      if (addr_valid) begin
        if (addr_q.size() == 0) chk("addr_q_underflow", 1, 0);
        else begin
          ea = addr_q.pop_front();
          chk("rom_addr", rom_addr_o, ea);
        end
      end
      if (mon_valid) begin
        if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rgb", rgb_o, e[EW-1 -: COLOR_W]);
          chk("hit_layer", hit_layer_o, e[LAYER_W:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic rand_px(input bit v);
    step($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, v);
  endtask

  task automatic near_px(input bit d, input bit v);
    int l;
    l = $urandom_range(0, N_LAYER - 1);
    step(clampi(a_x[l] + $urandom_range(0, 40) - 4, 0, 639),
         clampi(a_y[l] + $urandom_range(0, 40) - 4, 0, 479), d, v);
  endtask

  task automatic wr_layer(input int l, input bit vis, input int x, input int y, input bit v);
    cmd_uv = 1; cmd_ul = l; cmd_uvis = vis; cmd_ux = x; cmd_uy = y;
    rand_px(v);
  endtask

  task automatic commit_frame(input bit v);
    cmd_cr = 1; rand_px(v);
    rand_px(v); rand_px(v);
    cmd_fs = 1; rand_px(v);
    rand_px(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_LAYER * SPR_W * SPR_H; i++)
      rom_mem[i] = ($urandom_range(0, 15) == 0) ? TRANSP_KEY : COLOR_W'($urandom_range(1, 4095));
    rom_mem[5 * SPR_W + 5] = TRANSP_KEY;            // layer0 texel (5,5)
    rom_mem[1 * SPR_W * SPR_H] = 12'h123;           // layer1 texel (0,0)
    for (int l = 0; l < N_LAYER; l++) begin
      s_vis[l] = 0; s_x[l] = 0; s_y[l] = 0; a_vis[l] = 0; a_x[l] = 0; a_y[l] = 0;
    end

    // Reset, then a frame with no layers: background, address 0, no ack.
    cmd_rst = 1; step(0, 0, 0, 0);
    cmd_rst = 1; step(0, 0, 0, 0);
    mon_on = 1;
    for (int i = 0; i < 300; i++) step($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7) != 0, 1);
    cmd_fs = 1; rand_px(1);
    rand_px(1);

    // Layer 1 at (100,50).
    wr_layer(1, 1, 100, 50, 1);
    commit_frame(1);
    step(100, 50, 1, 1);
    step(132, 50, 1, 1);
    step(131, 81, 1, 1);
    step(99, 50, 1, 1);

    // Layers 0 and 2 overlapping: layer 0 wins.
    wr_layer(0, 1, 200, 200, 1);
    wr_layer(2, 1, 200, 200, 1);
    commit_frame(1);
    step(210, 205, 1, 1);
    step(231, 231, 1, 1);

    // Clipping at the bottom-right corner.
    wr_layer(0, 1, 630, 470, 1);
    wr_layer(2, 0, 0, 0, 1);
    wr_layer(3, 1, 620, 460, 1);
    commit_frame(1);
    step(639, 479, 1, 1);
    step(0, 0, 1, 1);
    step(635, 475, 1, 1);            // transparent layer0 texel over layer3
    step(625, 465, 1, 1);
    step(639, 479, 0, 1);

    // Commit request coinciding with frame_start, then a write while pending.
    cmd_cr = 1; cmd_fs = 1; rand_px(1);
    wr_layer(1, 0, 0, 0, 1);
    rand_px(1); rand_px(1);
    cmd_fs = 1; rand_px(1);
    rand_px(1);
    step(100, 50, 1, 1);

    // Display disabled: no hits, black output; commits still apply at frame start.
    rand_px(0); rand_px(0);
    cmd_en = 0;
    for (int i = 0; i < 4; i++) step(100, 50, 1, 1);
    wr_layer(2, 1, 300, 300, 1);
    cmd_cr = 1; step(101, 51, 1, 1);
    cmd_fs = 1; step(102, 52, 1, 1);
    step(100, 50, 1, 1);
    step(100, 50, 1, 0); step(100, 50, 1, 0);
    cmd_en = 1;
    step(100, 50, 1, 1);
    step(305, 305, 1, 1);

    // Reset mid-frame with layers active.
    for (int i = 0; i < 6; i++) near_px(1, 1);
    near_px(1, 0);
    cmd_rst = 1; near_px(1, 0);
    for (int i = 0; i < 6; i++) step(100 + i, 50, 1, 1);
    step(635, 475, 1, 1);

    // Randomised layer sets, commits and requests.
    for (int it = 0; it < 30; it++) begin
      for (int l = 0; l < N_LAYER; l++)
        wr_layer(l, $urandom_range(0, 3) != 0, $urandom_range(0, 639), $urandom_range(0, 479), 1);
      if ($urandom_range(0, 3) == 0) begin
        cmd_fs = 1; rand_px(1);
      end
      cmd_cr = 1; cmd_fs = ($urandom_range(0, 3) == 0); rand_px(1);
      if ($urandom_range(0, 1) == 1)
        wr_layer($urandom_range(0, 3), 1, $urandom_range(0, 639), $urandom_range(0, 479), 1);
      for (int k = 0; k < $urandom_range(0, 5); k++) near_px(1, 1);
      cmd_fs = 1; near_px(1, 1);
      for (int k = 0; k < 40; k++) near_px($urandom_range(0, 7) != 0, 1);
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("addr_q_drained", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
